// File: rtl/debug_step_scanner_if.sv
// Trace stream from debug_step_scanner to a sink: one captured register value per beat,
// tagged with its scan-list slot and scan number. valid/ready handshake.
interface debug_step_scanner_if #(
    parameter int DATA_W = 32,
    parameter int SLOT_W = 5,
    parameter int STEP_W = 16
);
    logic              dump_valid;
    logic              dump_ready;
    logic [DATA_W-1:0] dump_data;
    logic [SLOT_W-1:0] dump_slot;
    logic [STEP_W-1:0] dump_step;

    modport master (
        output dump_valid,
        output dump_data,
        output dump_slot,
        output dump_step,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_data,
        input  dump_slot,
        input  dump_step,
        output dump_ready
    );
endinterface

// File: rtl/debug_step_scanner.sv
// Walks a register scan list on the core's debug port, streams every captured value and
// steps the core between scans. Optional macro DEBUG_SCAN_DELTA_EN suppresses unchanged slots.
module debug_step_scanner #(
    parameter int DATA_W    = 32,
    parameter int SEL_W     = 5,
    parameter int NUM_SLOTS = 18,
    parameter int SETTLE    = 2,
    parameter int RUN_W     = 16,
    parameter int STEP_W    = 16
) (
    input  logic                       fastclk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [STEP_W-1:0]          num_steps,
    input  logic [NUM_SLOTS*SEL_W-1:0] slot_map,
    output logic [SEL_W-1:0]           switch_select,
    output logic                       switch_run,
    input  logic [DATA_W-1:0]          reg_read_data_1,
    debug_step_scanner_if.master       dump,
    output logic                       busy,
    output logic                       done
);
    localparam int SLOT_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_MAX = (RUN_W > SETTLE) ? RUN_W : SETTLE;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [CNT_W-1:0]  SETTLE_END = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0]  RUN_END    = CNT_W'(RUN_W - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEL  = 3'd1,
        HOLD = 3'd2,
        RUN  = 3'd3,
        POST = 3'd4,
        FIN  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              run_q, run_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SLOT_W-1:0] dslot_q, dslot_d;
    logic [STEP_W-1:0] dstep_q, dstep_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              adv_s;
    logic              skip_s;

    function automatic logic [SEL_W-1:0] slot_sel(input logic [NUM_SLOTS*SEL_W-1:0] map,
                                                  input logic [SLOT_W-1:0] idx);
        return map[idx*SEL_W +: SEL_W];
    endfunction

`ifdef DEBUG_SCAN_DELTA_EN
    logic [DATA_W-1:0] shadow_q [NUM_SLOTS];
    logic              capture_s;
    logic              clear_s;

    assign capture_s = (state_q == SEL) && (cnt_q == SETTLE_END) && !abort;
    assign clear_s   = start && !abort && ((state_q == IDLE) || (state_q == FIN));

    // Last captured value per slot, compared against on every scan after the first
    always_ff @(posedge fastclk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) shadow_q[i] <= '0;
        end else if (clear_s) begin
            for (int i = 0; i < NUM_SLOTS; i++) shadow_q[i] <= '0;
        end else if (capture_s) begin
            shadow_q[slot_q] <= reg_read_data_1;
        end
    end

    assign skip_s = (step_q != '0) && (reg_read_data_1 == shadow_q[slot_q]);
`else
    assign skip_s = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge fastclk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            slot_q  <= '0;
            step_q  <= '0;
            steps_q <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            run_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            dslot_q <= '0;
            dstep_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            step_q  <= step_d;
            steps_q <= steps_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            run_q   <= run_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            dslot_q <= dslot_d;
            dstep_q <= dstep_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; adv_s moves past the current slot whether it was sent or skipped
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        step_d  = step_q;
        steps_d = steps_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        run_d   = run_q;
        valid_d = valid_q;
        data_d  = data_q;
        dslot_d = dslot_q;
        dstep_d = dstep_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        adv_s   = 1'b0;

        if (abort) begin
            state_d = IDLE;
            run_d   = 1'b0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE, FIN: begin
                    if (start) begin
                        state_d = SEL;
                        busy_d  = 1'b1;
                        slot_d  = '0;
                        step_d  = '0;
                        steps_d = num_steps;
                        cnt_d   = '0;
                        sel_d   = slot_sel(slot_map, '0);
                    end else begin
                        state_d = IDLE;
                    end
                end
                SEL: begin
                    if (cnt_q == SETTLE_END) begin
                        if (skip_s) begin
                            adv_s = 1'b1;
                        end else begin
                            state_d = HOLD;
                            valid_d = 1'b1;
                            data_d  = reg_read_data_1;
                            dslot_d = slot_q;
                            dstep_d = step_q;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (dump.dump_ready) begin
                        valid_d = 1'b0;
                        adv_s   = 1'b1;
                    end else begin
                        valid_d = 1'b1;
                    end
                end
                RUN: begin
                    if (cnt_q == RUN_END) begin
                        state_d = POST;
                        run_d   = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                POST: begin
                    if (cnt_q == SETTLE_END) begin
                        state_d = SEL;
                        cnt_d   = '0;
                        slot_d  = '0;
                        step_d  = step_q + STEP_W'(1);
                        sel_d   = slot_sel(slot_map, '0);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    run_d   = 1'b0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase

            if (adv_s) begin
                cnt_d = '0;
                if (slot_q != LAST_SLOT) begin
                    state_d = SEL;
                    slot_d  = slot_q + SLOT_W'(1);
                    sel_d   = slot_sel(slot_map, slot_q + SLOT_W'(1));
                end else if (step_q != steps_q) begin
                    state_d = RUN;
                    run_d   = 1'b1;
                end else begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end else begin
                done_d = 1'b0;
            end
        end
    end

    assign switch_select   = sel_q;
    assign switch_run      = run_q;
    assign dump.dump_valid = valid_q;
    assign dump.dump_data  = data_q;
    assign dump.dump_slot  = dslot_q;
    assign dump.dump_step  = dstep_q;
    assign busy            = busy_q;
    assign done            = done_q;
endmodule

// File: tb/tb_debug_step_scanner.sv
// Bench for debug_step_scanner: table of sessions plus random sessions against a scan-list
// model, and hand-written abort / reset / backpressure sequences.
module tb_debug_step_scanner;
    localparam int DATA_W = 32, SEL_W = 5, NUM_SLOTS = 4, SETTLE = 2, RUN_W = 16, STEP_W = 16;
    localparam int SLOT_W = 2;
`ifdef DEBUG_SCAN_DELTA_EN
    localparam bit DELTA = 1'b1;
`else
    localparam bit DELTA = 1'b0;
`endif

    logic                       fastclk = 1'b0;
    logic                       reset = 1'b0;
    logic                       start = 1'b0;
    logic                       abort = 1'b0;
    logic [STEP_W-1:0]          num_steps = '0;
    logic [NUM_SLOTS*SEL_W-1:0] slot_map = {5'd19, 5'd18, 5'd17, 5'd16};
    logic [SEL_W-1:0]           switch_select;
    logic                       switch_run;
    logic [DATA_W-1:0]          reg_read_data_1;
    logic                       busy, done;

    debug_step_scanner_if #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .STEP_W(STEP_W)) dif ();

    debug_step_scanner #(
        .DATA_W(DATA_W), .SEL_W(SEL_W), .NUM_SLOTS(NUM_SLOTS),
        .SETTLE(SETTLE), .RUN_W(RUN_W), .STEP_W(STEP_W)
    ) dut (
        .fastclk(fastclk), .reset(reset), .start(start), .abort(abort),
        .num_steps(num_steps), .slot_map(slot_map), .switch_select(switch_select),
        .switch_run(switch_run), .reg_read_data_1(reg_read_data_1), .dump(dif),
        .busy(busy), .done(done)
    );

    always #5 fastclk = ~fastclk;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [SLOT_W-1:0] sl;
        logic [STEP_W-1:0] st;
        int                cyc;
    } beat_t;

    typedef struct {
        int n;
        int mode;
        int rdy;
        int exp_beats;
    } vec_t;

    int vecs = 0;
    int errs = 0;

    // Core model: value per (scan index, slot); scan index = run pulses seen this session
    logic [DATA_W-1:0] val_tab [8][4];
    int run_cnt = 0;
    int run_base = 0;

    always_comb begin
        int ri;
        ri = run_cnt - run_base;
        if (ri < 0) ri = 0;
        if (ri > 7) ri = 7;
        reg_read_data_1 = val_tab[ri][switch_select[1:0]];
    end

    // Monitor: beats, run pulse widths, done pulses, stability under backpressure
    beat_t beats[$];
    int    widths[$];
    int    done_cnt = 0, cyc = 0, run_len = 0, stall_chk = 0, stall_viol = 0;
    logic  run_prev = 1'b0, stall_prev = 1'b0;
    logic [DATA_W+SLOT_W+STEP_W+SEL_W:0] snap_prev = '0;

    always @(negedge fastclk) begin
        logic [DATA_W+SLOT_W+STEP_W+SEL_W:0] snap;
        cyc++;
        snap = {dif.dump_valid, dif.dump_data, dif.dump_slot, dif.dump_step, switch_select};
        if (stall_prev) begin
            stall_chk++;
            if (snap !== snap_prev) stall_viol++;
        end
        stall_prev = dif.dump_valid && !dif.dump_ready;
        snap_prev  = snap;
        if (dif.dump_valid && dif.dump_ready)
            beats.push_back('{dif.dump_data, dif.dump_slot, dif.dump_step, cyc});
        if (done) done_cnt++;
        if (switch_run) run_len++;
        else if (run_len != 0) begin
            widths.push_back(run_len);
            run_len = 0;
        end
        if (switch_run && !run_prev) run_cnt++;
        run_prev = switch_run;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack(input beat_t b);
        return {8'h00, b.d, 6'h00, b.sl, b.st};
    endfunction

    task automatic fill_vals(input int mode);
        for (int s = 0; s < 8; s++) begin
            for (int k = 0; k < 4; k++) begin
                case (mode)
                    0: val_tab[s][k] = 32'h110 + 32'(k);
                    1: val_tab[s][k] = 32'h110 + 32'(k) + ((k == 1) ? 32'(s) * 32'h1000 : 32'h0);
                    default: begin
                        if (s > 0 && $urandom_range(0, 1) == 0) val_tab[s][k] = val_tab[s-1][k];
                        else val_tab[s][k] = $urandom;
                    end
                endcase
            end
        end
    endtask

    task automatic session(input int n, input int mode, input int rdy, input int exp_beats,
                           input string tag);
        beat_t exp_q[$];
        int b0, w0, d0, sv0, stalls, budget, got;
        fill_vals(mode);
        for (int s = 0; s <= n; s++)
            for (int k = 0; k < 4; k++)
                if (!DELTA || s == 0 || val_tab[s][k] != val_tab[s-1][k])
                    exp_q.push_back('{val_tab[s][k], 2'(k), 16'(s), 0});
        b0 = beats.size(); w0 = widths.size(); d0 = done_cnt; sv0 = stall_viol;
        @(posedge fastclk); #1;
        run_base = run_cnt;
        num_steps = 16'(n);
        start = 1'b1;
        dif.dump_ready = 1'b1;
        @(posedge fastclk); #1;
        start = 1'b0;
        check({tag, "_busy_rise"}, 64'(busy), 64'd1);
        check({tag, "_sel_slot0"}, 64'(switch_select), 64'd16);
        stalls = 0; budget = 0;
        while (busy && budget < 4000) begin
            case (rdy)
                1: if (beats.size() - b0 == 1 && dif.dump_valid && stalls < 5) begin
                       dif.dump_ready = 1'b0;
                       stalls++;
                   end else dif.dump_ready = 1'b1;
                2: dif.dump_ready = ($urandom_range(0, 2) != 0);
                default: dif.dump_ready = 1'b1;
            endcase
            @(posedge fastclk); #1;
            budget++;
        end
        dif.dump_ready = 1'b1;
        check({tag, "_timeout"}, 64'(busy), 64'd0);
        repeat (3) @(posedge fastclk);
        #1;
        got = beats.size() - b0;
        check({tag, "_beat_count"}, 64'(got), 64'(exp_q.size()));
        if (exp_beats >= 0) check({tag, "_beat_count_tab"}, 64'(got), 64'(exp_beats));
        for (int i = 0; i < exp_q.size() && i < got; i++)
            check({tag, "_beat"}, pack(beats[b0+i]), pack(exp_q[i]));
        check({tag, "_run_pulses"}, 64'(widths.size() - w0), 64'(n));
        for (int i = w0; i < widths.size(); i++)
            check({tag, "_run_width"}, 64'(widths[i]), 64'(RUN_W));
        check({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
        check({tag, "_stall_stable"}, 64'(stall_viol - sv0), 64'd0);
        if (rdy == 1) check({tag, "_stall_cycles"}, 64'(stalls), 64'd5);
        if (rdy == 0)
            for (int i = b0 + 1; i < beats.size(); i++)
                if (beats[i].st == beats[i-1].st && beats[i].sl == beats[i-1].sl + 2'd1)
                    check({tag, "_spacing"}, 64'(beats[i].cyc - beats[i-1].cyc), 64'(SETTLE + 1));
    endtask

    task automatic wait_run(input string tag);
        int bud;
        bud = 0;
        while (!switch_run && bud < 500) begin
            @(posedge fastclk); #1;
            bud++;
        end
        check({tag, "_run_seen"}, 64'(switch_run), 64'd1);
    endtask

    vec_t vt[5];

    initial begin
        int idle_bad, d0;
        vt[0] = '{0, 0, 0, 4};
        vt[1] = '{2, 0, 0, DELTA ? 4 : 12};
        vt[2] = '{0, 0, 1, 4};
        vt[3] = '{1, 1, 0, DELTA ? 5 : 8};
        vt[4] = '{2, 2, 2, -1};
        dif.dump_ready = 1'b1;
        fill_vals(0);

        repeat (3) @(negedge fastclk);
        check("rst_sel", 64'(switch_select), 64'd0);
        check("rst_run", 64'(switch_run), 64'd0);
        check("rst_valid", 64'(dif.dump_valid), 64'd0);
        check("rst_data", 64'(dif.dump_data), 64'd0);
        check("rst_slot", 64'(dif.dump_slot), 64'd0);
        check("rst_step", 64'(dif.dump_step), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        @(posedge fastclk); #1;
        reset = 1'b1;

        idle_bad = 0;
        repeat (100) begin
            @(negedge fastclk);
            if (switch_run || dif.dump_valid || busy || done || switch_select != 5'd0) idle_bad++;
        end
        check("idle_100", 64'(idle_bad), 64'd0);

        for (int i = 0; i < 5; i++)
            session(vt[i].n, vt[i].mode, vt[i].rdy, vt[i].exp_beats, $sformatf("vec%0d", i));

        for (int i = 0; i < 6; i++)
            session($urandom_range(0, 3), 2, 2, -1, $sformatf("rnd%0d", i));

        // Abort during the fifth cycle of the run pulse
        fill_vals(0);
        d0 = done_cnt;
        @(posedge fastclk); #1;
        num_steps = 16'd2; start = 1'b1; dif.dump_ready = 1'b1;
        @(posedge fastclk); #1;
        start = 1'b0;
        wait_run("abort");
        repeat (4) @(posedge fastclk);
        #1;
        abort = 1'b1;
        @(posedge fastclk); #1;
        abort = 1'b0;
        check("abort_run", 64'(switch_run), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(dif.dump_valid), 64'd0);
        repeat (5) @(posedge fastclk);
        #1;
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        session(0, 0, 0, 4, "after_abort");

        // abort and start together: abort wins
        @(posedge fastclk); #1;
        abort = 1'b1; start = 1'b1;
        @(posedge fastclk); #1;
        abort = 1'b0; start = 1'b0;
        check("abort_over_start", 64'(busy), 64'd0);

        // Reset mid-run: switch_run must drop without a clock edge
        @(posedge fastclk); #1;
        num_steps = 16'd1; start = 1'b1;
        @(posedge fastclk); #1;
        start = 1'b0;
        wait_run("rst");
        #2;
        reset = 1'b0;
        #1;
        check("rst_async_run", 64'(switch_run), 64'd0);
        check("rst_async_busy", 64'(busy), 64'd0);
        check("rst_async_sel", 64'(switch_select), 64'd0);
        @(posedge fastclk); #1;
        reset = 1'b1;
        session(1, 1, 0, DELTA ? 5 : 8, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
